// File: rtl/csa_operand_collector.sv
// Operand collector and result capture wrapped around the M-operand CSA.
// Optional self-check accumulator and chk_err port: define CSA_COLLECT_CHECK_EN.
module csa_operand_collector #(
   parameter int M = 8,
   parameter int N = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0]             in_data,
   input  logic                     in_last,
   output logic [M*N-1:0]           csa_ops,
   input  logic [N+M-3:0]           csa_sum,
   input  logic                     csa_cout,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [N+M-2:0]           res_data,
   output logic [$clog2(M+1)-1:0]   res_count
`ifdef CSA_COLLECT_CHECK_EN
   ,
   output logic                     chk_err
`endif
);

   localparam int RW = N + M - 1;
   localparam int CW = $clog2(M + 1);
   localparam int IW = $clog2(M);

   typedef enum logic [1:0] {
      COLLECT,
      SETTLE,
      HOLD
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic [M*N-1:0]  ops;
   logic            hs;
   logic            grp_end;

   assign hs      = in_valid & in_ready;
   assign grp_end = in_last | (idx == IW'(M - 1));
   assign csa_ops = ops;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= COLLECT;
         idx       <= '0;
         cnt       <= '0;
         ops       <= '0;
         in_ready  <= 1'b1;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_count <= '0;
      end else begin
         unique case (state)
            COLLECT: begin
               if (hs) begin
                  // An early in_last zero-fills every slot above the last one
                  for (int k = 0; k < M; k++) begin
                     if (k == int'(idx))
                        ops[k*N +: N] <= in_data;
                     else if (in_last && k > int'(idx))
                        ops[k*N +: N] <= '0;
                  end
                  idx <= idx + IW'(1);
                  if (grp_end) begin
                     cnt      <= CW'(idx) + CW'(1);
                     in_ready <= 1'b0;
                     state    <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               res_data  <= {csa_cout, csa_sum};
               res_count <= cnt;
               res_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  idx       <= '0;
                  ops       <= '0;
                  in_ready  <= 1'b1;
                  state     <= COLLECT;
               end
            end
            default: begin
               state    <= COLLECT;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef CSA_COLLECT_CHECK_EN
   logic [RW-1:0] acc;

   // Reference sum built from the accepted stream, independent of csa_ops
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc     <= '0;
         chk_err <= 1'b0;
      end else begin
         if (state == COLLECT && hs)
            acc <= acc + RW'(in_data);
         else if (state == HOLD && res_ready)
            acc <= '0;
         if (state == SETTLE && acc != {csa_cout, csa_sum}) begin
            chk_err <= 1'b1;
`ifndef SYNTHESIS
            $error("csa_operand_collector: adder result %0d, expected %0d",
                   {csa_cout, csa_sum}, acc);
`endif
         end
      end
   end
`endif

endmodule

// File: tb/tb_csa_operand_collector.sv
// Scoreboard bench for csa_operand_collector (M=8, N=4) with a behavioural adder.
module tb_csa_operand_collector;

   localparam int M  = 8;
   localparam int N  = 4;
   localparam int RW = N + M - 1;
   localparam int CW = $clog2(M + 1);

   typedef struct {
      logic [RW-1:0] data;
      logic [CW-1:0] count;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [N-1:0]    in_data;
   logic            in_last;
   logic [M*N-1:0]  csa_ops;
   logic [RW-2:0]   csa_sum;
   logic            csa_cout;
   logic            res_valid;
   logic            res_ready;
   logic [RW-1:0]   res_data;
   logic [CW-1:0]   res_count;
   logic            flip;
   logic [RW-1:0]   s;
`ifdef CSA_COLLECT_CHECK_EN
   logic            chk_err;
`endif

   exp_t sb[$];
   int ntest = 0;
   int nfail = 0;

   csa_operand_collector #(.M(M), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .csa_ops   (csa_ops),
      .csa_sum   (csa_sum),
      .csa_cout  (csa_cout),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_count (res_count)
`ifdef CSA_COLLECT_CHECK_EN
      ,
      .chk_err   (chk_err)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural stand-in for the combinational carry-save adder
   always_comb begin
      s = '0;
      for (int k = 0; k < M; k++)
         s = s + RW'(csa_ops[k*N +: N]);
   end
   assign csa_sum  = s[RW-2:0] ^ {{(RW-2){1'b0}}, flip};
   assign csa_cout = s[RW-1];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            ntest++;
            nfail++;
            $display("FAIL spurious_result: got %0d, expected none", res_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_data", 64'(res_data), 64'(e.data));
            chk("res_count", 64'(res_count), 64'(e.count));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-1:0] d, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         ntest++;
         nfail++;
         $display("FAIL send_timeout: got in_ready=0, expected 1");
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic push(input int d, input int c);
      exp_t e;
      e.data  = RW'(d);
      e.count = CW'(c);
      sb.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         ntest++;
         nfail++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      res_ready = 1'b1;
      flip      = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_res_valid", 64'(res_valid), 0);
      chk("rst_res_data", 64'(res_data), 0);
      chk("rst_res_count", 64'(res_count), 0);
      chk("rst_csa_ops", 64'(csa_ops), 0);

      // 1..8: handshake cycle, SETTLE cycle, then one cycle of res_valid
      push(36, 8);
      for (int i = 1; i <= 8; i++)
         send(N'(i), 1'b0);
      chk("lat_settle", 64'(res_valid), 0);
      chk("lat_settle_rdy", 64'(in_ready), 0);
      tick();
      chk("lat_valid", 64'(res_valid), 1);
      tick();
      chk("lat_drop", 64'(res_valid), 0);
      chk("lat_rdy_back", 64'(in_ready), 1);

      push(120, 8);
      for (int i = 0; i < 8; i++)
         send(4'hF, 1'b0);
      drain();

      push(18, 3);
      send(4'd5, 1'b0);
      send(4'd6, 1'b0);
      send(4'd7, 1'b1);
      chk("early_last_ops", 64'(csa_ops), 64'h0000_0765);
      drain();

      // Stall in HOLD with a pending operand on the input
      res_ready = 1'b0;
      push(3, 3);
      send(4'd1, 1'b0);
      send(4'd1, 1'b0);
      send(4'd1, 1'b1);
      tick();
      in_valid = 1'b1;
      in_data  = 4'd9;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 64'(res_valid), 1);
         chk("hold_data", 64'(res_data), 3);
         chk("hold_in_ready", 64'(in_ready), 0);
         tick();
      end
      chk("hold_ops", 64'(csa_ops), 64'h0000_0111);
      in_valid  = 1'b0;
      res_ready = 1'b1;
      tick();
      chk("release_ready", 64'(in_ready), 1);
      chk("release_ops", 64'(csa_ops), 0);
      push(8, 2);
      send(4'd4, 1'b0);
      send(4'd4, 1'b1);
      drain();

      // Reset mid-group: partial group must vanish
      for (int i = 0; i < 4; i++)
         send(4'd3, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_ops", 64'(csa_ops), 0);
      chk("mid_rst_valid", 64'(res_valid), 0);
      chk("mid_rst_ready", 64'(in_ready), 1);
      push(16, 8);
      for (int i = 0; i < 8; i++)
         send(4'd2, 1'b0);
      drain();

      // Back-to-back groups with random gaps; last one ends with in_last
      push(80, 8);
      push(30, 4);
      push(119, 8);
      for (int i = 0; i < 8; i++) begin
         send(4'd10, 1'b0);
         repeat ($urandom_range(0, 2)) tick();
      end
      send(4'd3, 1'b0);
      send(4'd0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
      send(4'd12, 1'b0);
      send(4'd15, 1'b1);
      for (int i = 0; i < 7; i++) begin
         send(4'd15, 1'b0);
         repeat ($urandom_range(0, 2)) tick();
      end
      send(4'd14, 1'b1);
      drain();

`ifdef CSA_COLLECT_CHECK_EN
      chk("chk_err_clean", 64'(chk_err), 0);
      flip = 1'b1;
      push(9, 8);
      for (int i = 0; i < 8; i++)
         send(4'd1, 1'b0);
      drain();
      flip = 1'b0;
      chk("chk_err_set", 64'(chk_err), 1);
      push(8, 8);
      for (int i = 0; i < 8; i++)
         send(4'd1, 1'b0);
      drain();
      chk("chk_err_sticky", 64'(chk_err), 1);
`endif

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
